// File: rtl/nios_core_pio_pkg.sv
// Shared constants for the debounced key PIO: register word addresses and
// per-channel edge-mode encodings.
package nios_core_pio_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SYNC   = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_MODE   = 3'd4;
   localparam logic [2:0] ADDR_THRESH = 3'd5;

   localparam logic [1:0] EM_NONE = 2'b00;
   localparam logic [1:0] EM_RISE = 2'b01;
   localparam logic [1:0] EM_FALL = 2'b10;
   localparam logic [1:0] EM_BOTH = 2'b11;

   // Decide whether a debounced transition is of interest under a given mode.
   function automatic logic edge_hit(input logic [1:0] mode, input logic rise,
                                     input logic fall);
      logic hit;
      hit = 1'b0;
      case (mode)
         EM_RISE: hit = rise;
         EM_FALL: hit = fall;
         EM_BOTH: hit = rise | fall;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/nios_core_pio_db_chan.sv
// One key channel: input synchronizer, saturating debounce counter, debounced
// state flop and edge detector on the debounced state.
module nios_core_pio_db_chan
   import nios_core_pio_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_i,
   input  logic [15:0] thresh_i,
   input  logic [1:0]  mode_i,
   output logic        sync_o,
   output logic        stable_o,
   output logic        edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [15:0]            cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   prev_q;
   logic                   rise, fall;

   assign sync = sync_q[SYNC_STAGES-1];

   // Shift the raw key through the synchronizer chain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      end
   end

   // Count consecutive disagreeing cycles; accept the new level once the count
   // has reached the threshold. >= keeps a lowered threshold effective at once.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync != stable_q) begin
         if (cnt_q >= thresh_i) begin
            stable_d = sync;
         end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   // Debounce state; keys are active-low so released (1) is the reset level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         stable_q <= 1'b1;
         prev_q   <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         prev_q   <= stable_q;
      end
   end

   assign rise     = stable_q & ~prev_q;
   assign fall     = ~stable_q & prev_q;
   assign edge_o   = edge_hit(mode_i, rise, fall);
   assign sync_o   = sync;
   assign stable_o = stable_q;

endmodule

// File: rtl/nios_core_pio_key_db.sv
// Avalon-MM key PIO with per-channel debouncing, configurable edge capture
// and a masked interrupt.
module nios_core_pio_key_db
   import nios_core_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter logic [15:0] DB_DEFAULT  = 16'd50000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0]   sync_vec, stable_vec, edge_det;
   logic [WIDTH-1:0]   mask_q, mask_d;
   logic [WIDTH-1:0]   cap_q, cap_d;
   logic [WIDTH-1:0]   clr;
   logic [2*WIDTH-1:0] mode_q, mode_d;
   logic [15:0]        thresh_q, thresh_d;
   logic [31:0]        rd_q, rd_d;
   logic               wr_en;
   logic               unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_chan
      nios_core_pio_db_chan #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
         .clk_i   (clk),
         .rst_ni  (reset_n),
         .in_i    (in_port[g]),
         .thresh_i(thresh_q),
         .mode_i  (mode_q[2*g +: 2]),
         .sync_o  (sync_vec[g]),
         .stable_o(stable_vec[g]),
         .edge_o  (edge_det[g])
      );
   end

   // Register writes, write-1-to-clear capture (a fresh edge wins) and read mux.
   always_comb begin
      mask_d   = mask_q;
      mode_d   = mode_q;
      thresh_d = thresh_q;
      clr      = '0;
      if (wr_en) begin
         case (address)
            ADDR_MASK:   mask_d   = writedata[WIDTH-1:0];
            ADDR_EDGE:   clr      = writedata[WIDTH-1:0];
            ADDR_MODE:   mode_d   = writedata[2*WIDTH-1:0];
            ADDR_THRESH: thresh_d = writedata[15:0];
            default:     ;
         endcase
      end
      cap_d = (cap_q & ~clr) | edge_det;

      rd_d = '0;
      case (address)
         ADDR_DATA:   rd_d[WIDTH-1:0]   = stable_vec;
         ADDR_SYNC:   rd_d[WIDTH-1:0]   = sync_vec;
         ADDR_MASK:   rd_d[WIDTH-1:0]   = mask_q;
         ADDR_EDGE:   rd_d[WIDTH-1:0]   = cap_q;
         ADDR_MODE:   rd_d[2*WIDTH-1:0] = mode_q;
         ADDR_THRESH: rd_d[15:0]        = thresh_q;
         default:     ;
      endcase
   end

   // Control/status registers and the registered read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q   <= '0;
         cap_q    <= '0;
         mode_q   <= {WIDTH{EM_FALL}};
         thresh_q <= DB_DEFAULT;
         rd_q     <= '0;
      end else begin
         mask_q   <= mask_d;
         cap_q    <= cap_d;
         mode_q   <= mode_d;
         thresh_q <= thresh_d;
         rd_q     <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_core_pio_key_db.sv
// Randomized scoreboard bench for the debounced key PIO.
module tb_nios_core_pio_key_db;

   localparam int          W    = 4;
   localparam int          SYNC = 2;
   localparam logic [15:0] DBD  = 16'd50000;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic [2:0]     address = '0;
   logic           chipselect = 1'b0;
   logic           write_n = 1'b1;
   logic [31:0]    writedata = '0;
   logic [W-1:0]   in_port = '1;
   logic [31:0]    readdata;
   logic           irq;

   int n_checks = 0;
   int n_pass   = 0;

   nios_core_pio_key_db #(
      .WIDTH      (W),
      .DB_DEFAULT (DBD),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (readdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   // ---------------- reference model ----------------
   logic [W-1:0]   hist[$];      // synchronizer contents, [0] = visible sync value
   logic [W-1:0]   m_stable, m_prev, m_cap, m_mask;
   logic [2*W-1:0] m_mode;
   logic [15:0]    m_thresh;
   int             m_diff[W];    // consecutive cycles sync has disagreed with stable
   logic [31:0]    exp_q[$];

   function automatic logic [31:0] model_read(input logic [2:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         3'd0: r[W-1:0]   = m_stable;
         3'd1: r[W-1:0]   = hist[0];
         3'd2: r[W-1:0]   = m_mask;
         3'd3: r[W-1:0]   = m_cap;
         3'd4: r[2*W-1:0] = m_mode;
         3'd5: r[15:0]    = m_thresh;
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back('0);
      m_stable = '1;
      m_prev   = '1;
      m_cap    = '0;
      m_mask   = '0;
      m_mode   = {W{2'b10}};
      m_thresh = DBD;
      for (int i = 0; i < W; i++) m_diff[i] = 0;
   endtask

   task automatic model_step();
      logic [W-1:0] sync, nstable, det, clr;
      logic [1:0]   md;
      logic         rose, fell, wr;
      exp_q.push_back(model_read(address));
      wr      = chipselect && !write_n;
      sync    = hist[0];
      nstable = m_stable;
      det     = '0;
      for (int ch = 0; ch < W; ch++) begin
         if (sync[ch] != m_stable[ch]) begin
            m_diff[ch]++;
            // accept after threshold+1 consecutive disagreeing cycles
            if (m_diff[ch] >= int'(m_thresh) + 1) begin
               nstable[ch] = sync[ch];
               m_diff[ch]  = 0;
            end
         end else begin
            m_diff[ch] = 0;
         end
         rose = m_stable[ch] && !m_prev[ch];
         fell = !m_stable[ch] && m_prev[ch];
         md   = m_mode[2*ch +: 2];
         det[ch] = (rose && (md == 2'b01 || md == 2'b11)) ||
                   (fell && (md == 2'b10 || md == 2'b11));
      end
      clr   = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~clr) | det;
      if (wr) begin
         case (address)
            3'd2: m_mask   = writedata[W-1:0];
            3'd4: m_mode   = writedata[2*W-1:0];
            3'd5: m_thresh = writedata[15:0];
            default: ;
         endcase
      end
      m_prev   = m_stable;
      m_stable = nstable;
      hist.push_back(in_port);
      void'(hist.pop_front());
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   // ---------------- monitor ----------------
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0) check("readdata", readdata, exp_q.pop_front());
         check("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      #1 reset_n = 1'b0;
      in_port = '1;
      #1;
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         address    = 3'($urandom_range(0, 7));
         chipselect = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      chipselect = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string name);
      address = a;
      @(negedge clk);
      check(name, readdata, exp);
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      int          r;

      // Debounce with threshold 3, then a short glitch that must be rejected.
      do_reset();
      bus_write(3'd5, 32'd3);
      bus_write(3'd2, 32'd1);
      in_port[0] = 1'b0;
      idle(12);
      check("s032_irq", {31'd0, irq}, 32'd1);
      do_read(3'd0, 32'hE, "s032_stable");
      do_read(3'd3, 32'h1, "s032_cap");
      in_port[1] = 1'b0;
      idle(3);
      in_port[1] = 1'b1;
      idle(8);
      do_read(3'd0, 32'hE, "s033_stable");
      do_read(3'd3, 32'h1, "s033_cap");

      // Rise-only on ch2, both on ch3, interrupt masked.
      do_reset();
      bus_write(3'd4, 32'hDA);
      bus_write(3'd5, 32'd0);
      bus_write(3'd2, 32'd0);
      in_port[3:2] = 2'b00;
      idle(6);
      do_read(3'd3, 32'h8, "s034_cap_fall");
      in_port[3:2] = 2'b11;
      idle(6);
      do_read(3'd3, 32'hC, "s034_cap_rise");
      check("s034_irq", {31'd0, irq}, 32'd0);

      // Write-1-to-clear and set-beats-clear.
      do_reset();
      bus_write(3'd5, 32'd0);
      in_port = 4'b0100;
      idle(6);
      do_read(3'd3, 32'hB, "s035_cap_set");
      bus_write(3'd3, 32'h2);
      do_read(3'd3, 32'h9, "s035_w1c");
      in_port[0] = 1'b1;
      idle(6);
      bus_write(3'd3, 32'h1);
      in_port[0] = 1'b0;          // sync after 2 edges, stable after 3, capture on 4th
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      bus_write(3'd3, 32'h1);     // clear lands on the same edge as the capture
      do_read(3'd3, 32'h9, "s035_set_wins");

      // Unmapped addresses and register readback latency.
      bus_write(3'd6, 32'hFFFF_FFFF);
      bus_write(3'd7, 32'hFFFF_FFFF);
      bus_write(3'd1, 32'hFFFF_FFFF);
      do_read(3'd6, 32'd0, "s036_addr6");
      do_read(3'd7, 32'd0, "s036_addr7");
      do_read(3'd5, 32'd0, "s036_thresh");

      // Reset in the middle of a debounce count.
      do_reset();
      bus_write(3'd5, 32'd100);
      address    = 3'd0;
      in_port[0] = 1'b0;
      repeat (20) @(negedge clk);
      do_reset();
      do_read(3'd3, 32'd0, "s037_cap");
      do_read(3'd0, 32'hF, "s037_stable");
      do_read(3'd5, 32'(DBD), "s037_thresh");
      do_read(3'd4, 32'hAA, "s037_mode");
      do_read(3'd2, 32'd0, "s037_mask");

      // Randomized traffic checked cycle by cycle against the model.
      do_reset();
      bus_write(3'd5, 32'd2);
      for (int it = 0; it < 4000; it++) begin
         if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
         r = $urandom_range(0, 99);
         if (r < 6) begin
            d = $urandom;
            d[15:0] = 16'($urandom_range(0, 6));
            bus_write(3'd5, d);
         end else if (r < 12) begin
            bus_write(3'd2, $urandom);
         end else if (r < 18) begin
            bus_write(3'd4, $urandom);
         end else if (r < 26) begin
            bus_write(3'd3, $urandom);
         end else if (r < 30) begin
            bus_write(3'($urandom_range(0, 7)), $urandom);
         end else begin
            idle(1);
         end
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nios_core_pio_key_db.md
NIOS_CORE_PIO_KEY_DB -- requirements
Module: nios_core_pio_key_db

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of input channels, legal 1..16.
REQ-002 SHALL have parameter DB_DEFAULT, default 16'd50000, reset value of the debounce threshold register.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth, legal 2..4.
REQ-004 clk  in  1  sole clock; one clock domain, all registers on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 address  in  3  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 in_port  in  WIDTH  asynchronous key inputs.
REQ-011 readdata  out  32  registered read data.
REQ-012 irq  out  1  interrupt request.

Function
REQ-013 SHALL pass each in_port bit through a SYNC_STAGES flop chain; its last stage is "sync".
REQ-014 Per channel, SHALL hold a debounced state "stable" and a 16-bit counter; counter clears when sync==stable, else increments.
REQ-015 When the counter reaches threshold while sync!=stable, stable SHALL take sync next cycle and the counter SHALL clear; stable changes only after threshold+1 consecutive differing cycles.
REQ-016 Threshold 0 SHALL give stable = sync delayed one cycle (no filtering).
REQ-017 Counter SHALL saturate, never wrap; a threshold write resets no counter.
REQ-018 Edge mode per channel, 2 bits: 00 none, 01 rising, 10 falling, 11 both; detection is on stable transitions only.
REQ-019 A detected edge SHALL set its edge_capture bit the cycle after stable changes.
REQ-020 Write to address 3 SHALL clear each edge_capture bit where writedata bit is 1 (write-1-to-clear); 0 bits unchanged.
REQ-021 Edge detect and write-1-clear on the same bit in the same cycle: set SHALL win.
REQ-022 irq SHALL equal OR over (edge_capture & irq_mask), combinational from registers.
REQ-023 Register map: 0 stable (RO); 1 sync raw (RO); 2 irq_mask (RW, WIDTH bits); 3 edge_capture (RW1C); 4 edge_mode (RW, 2*WIDTH bits, channel n at [2n+1:2n]); 5 threshold (RW, 16 bits); 6,7 read 0, writes ignored.
REQ-024 readdata SHALL be registered every cycle from address regardless of chipselect, one-cycle latency; unused upper bits 0.
REQ-025 Writes SHALL occur when chipselect && !write_n, take effect next cycle; writes to RO addresses ignored.
REQ-026 Edge-mode change SHALL not itself generate an edge; only subsequent stable transitions count.

Reset
REQ-027 On reset_n low, SHALL asynchronously clear readdata, irq_mask, edge_capture, counters, synchronizer flops; stable SHALL reset to all ones (keys released, active-low).
REQ-028 edge_mode SHALL reset to all 10 (falling); threshold SHALL reset to DB_DEFAULT.
REQ-029 Reset mid-debounce SHALL abandon the count; no edge SHALL be captured due to reset release.

Structure
REQ-030 Package nios_core_pio_pkg SHALL hold address constants (ADDR_DATA..ADDR_THRESH) and edge-mode encodings (EM_NONE, EM_RISE, EM_FALL, EM_BOTH).
REQ-031 Per-channel synchronizer, counter, stable flop and edge detect SHALL be sub-module nios_core_pio_db_chan, instantiated WIDTH times by generate.

Verification
REQ-032 Threshold=3, in_port[0] 1->0 held: stable[0] falls 4 cycles after sync[0] falls; edge_capture[0]=1 next cycle; irq=1 with irq_mask=1.
REQ-033 Threshold=3, in_port[1] glitches low 3 cycles then high: stable[1] stays 1, edge_capture stays 0.
REQ-034 edge_mode ch2=01, 11 on ch3: drive 0->1->0 on both; capture[2] set only on rise, capture[3] on both; irq_mask=0 keeps irq=0.
REQ-035 edge_capture=4'b1011, write 4'b0010 to address 3 -> reads 4'b1001; same-cycle edge on bit 0 with clear writedata 1 -> bit 0 stays 1.
REQ-036 Threshold=0: stable tracks sync with one-cycle delay; reads at addresses 6,7 return 0; read latency exactly 1 cycle.
REQ-037 Assert reset_n mid-count: all registers at reset values immediately; after release with in_port=all ones, no capture bit set.
